// File: rtl/bidir_dly_line.sv
// Half-duplex bidirectional delay line: one direction drives at a time; each direction has its own delay.
// Define BIDIR_DLY_COLL_CNT_EN to add the saturating 8-bit collision counter output coll_cnt.
module bidir_dly_line #(
    parameter int LANES   = 8,
    parameter int MAX_DLY = 15,
    parameter int DLYW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_oe,
    input  logic [LANES-1:0] a_dq,
    input  logic             b_oe,
    input  logic [LANES-1:0] b_dq,
    input  logic [DLYW-1:0]  cfg_dly_a2b,
    input  logic [DLYW-1:0]  cfg_dly_b2a,
    output logic             b_rx_vld,
    output logic [LANES-1:0] b_rx_dq,
    output logic             a_rx_vld,
    output logic [LANES-1:0] a_rx_dq,
    output logic [1:0]       dir,
    output logic             collision
`ifdef BIDIR_DLY_COLL_CNT_EN
    ,
    output logic [7:0]       coll_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        A2B  = 2'd1,
        B2A  = 2'd2,
        TURN = 2'd3
    } state_t;

    typedef struct packed {
        logic             vld;
        logic [LANES-1:0] dq;
    } stage_t;

    localparam int IDXW = (MAX_DLY > 1) ? $clog2(MAX_DLY) : 1;

    function automatic logic [DLYW-1:0] clamp_dly(input logic [DLYW-1:0] cfg);
        if (cfg == '0)
            return DLYW'(1);
        if (int'(cfg) > MAX_DLY)
            return DLYW'(MAX_DLY);
        return cfg;
    endfunction

    state_t          state, next_state;
    stage_t          a2b_pipe [MAX_DLY];
    stage_t          b2a_pipe [MAX_DLY];
    logic [DLYW-1:0] dly_a2b, dly_b2a;
    logic [DLYW-1:0] tap_a2b, tap_b2a;
    logic [IDXW-1:0] idx_a2b, idx_b2a;
    logic            inj_a, inj_b, coll_evt;
    logic            a2b_busy, b2a_busy;

    assign dir = state;

    // A word enters at stage D-1 and walks towards stage 0, so it leaves the pipeline
    // exactly when it is registered onto the rx outputs D edges later.
    assign idx_a2b = IDXW'(tap_a2b - DLYW'(1));
    assign idx_b2a = IDXW'(tap_b2a - DLYW'(1));

    always_comb begin
        a2b_busy = 1'b0;
        b2a_busy = 1'b0;
        for (int i = 0; i < MAX_DLY; i++) begin
            a2b_busy = a2b_busy | a2b_pipe[i].vld;
            b2a_busy = b2a_busy | b2a_pipe[i].vld;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        inj_a      = 1'b0;
        inj_b      = 1'b0;
        coll_evt   = 1'b0;
        tap_a2b    = dly_a2b;
        tap_b2a    = dly_b2a;
        unique case (state)
            IDLE: begin
                // The delay of a new transfer comes from cfg as it is latched on the start edge.
                tap_a2b = clamp_dly(cfg_dly_a2b);
                tap_b2a = clamp_dly(cfg_dly_b2a);
                if (a_oe && b_oe) begin
                    coll_evt = 1'b1;
                end else if (a_oe) begin
                    inj_a      = 1'b1;
                    next_state = A2B;
                end else if (b_oe) begin
                    inj_b      = 1'b1;
                    next_state = B2A;
                end
            end
            A2B: begin
                coll_evt = b_oe;
                if (a_oe) inj_a = 1'b1;
                else      next_state = TURN;
            end
            B2A: begin
                coll_evt = a_oe;
                if (b_oe) inj_b = 1'b1;
                else      next_state = TURN;
            end
            TURN: begin
                coll_evt = a_oe | b_oe;
                if (!a2b_busy && !b2a_busy) next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            collision <= 1'b0;
            dly_a2b   <= DLYW'(1);
            dly_b2a   <= DLYW'(1);
            b_rx_vld  <= 1'b0;
            b_rx_dq   <= '0;
            a_rx_vld  <= 1'b0;
            a_rx_dq   <= '0;
            // NOTE: the pipeline storage is reset on purpose so in-flight words can never surface after rst.
            for (int i = 0; i < MAX_DLY; i++) begin
                a2b_pipe[i] <= '0;
                b2a_pipe[i] <= '0;
            end
        end else begin
            state <= next_state;
            if (coll_evt) collision <= 1'b1;
            if (state == IDLE) begin
                dly_a2b <= tap_a2b;
                dly_b2a <= tap_b2a;
            end

            b_rx_vld <= a2b_pipe[0].vld;
            b_rx_dq  <= a2b_pipe[0].dq;
            a_rx_vld <= b2a_pipe[0].vld;
            a_rx_dq  <= b2a_pipe[0].dq;

            for (int i = 0; i < MAX_DLY - 1; i++) begin
                a2b_pipe[i] <= a2b_pipe[i+1];
                b2a_pipe[i] <= b2a_pipe[i+1];
            end
            a2b_pipe[MAX_DLY-1] <= '0;
            b2a_pipe[MAX_DLY-1] <= '0;

            // NOTE: non-blocking assignments to the same stage later in the block win, so injection overrides the shift.
            if (inj_a) a2b_pipe[idx_a2b] <= '{vld: 1'b1, dq: a_dq};
            if (inj_b) b2a_pipe[idx_b2a] <= '{vld: 1'b1, dq: b_dq};
        end
    end

`ifdef BIDIR_DLY_COLL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            coll_cnt <= '0;
        else if (coll_evt && coll_cnt != 8'hFF)
            coll_cnt <= coll_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_bidir_dly_line.sv
// Self-checking bench for bidir_dly_line: timeline-based reference model plus directed literal scenarios.
// Define BIDIR_DLY_COLL_CNT_EN for both bench and RTL to also check coll_cnt.
module tb_bidir_dly_line;
    localparam int LANES   = 8;
    localparam int MAX_DLY = 15;
    localparam int DLYW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             a_oe = 1'b0, b_oe = 1'b0;
    logic [LANES-1:0] a_dq = '0, b_dq = '0;
    logic [DLYW-1:0]  cfg_dly_a2b = DLYW'(1), cfg_dly_b2a = DLYW'(1);
    logic             b_rx_vld, a_rx_vld, collision;
    logic [LANES-1:0] b_rx_dq, a_rx_dq;
    logic [1:0]       dir;
`ifdef BIDIR_DLY_COLL_CNT_EN
    logic [7:0]       coll_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    bidir_dly_line #(.LANES(LANES), .MAX_DLY(MAX_DLY), .DLYW(DLYW)) dut (
        .clk         (clk),
        .rst         (rst),
        .a_oe        (a_oe),
        .a_dq        (a_dq),
        .b_oe        (b_oe),
        .b_dq        (b_dq),
        .cfg_dly_a2b (cfg_dly_a2b),
        .cfg_dly_b2a (cfg_dly_b2a),
        .b_rx_vld    (b_rx_vld),
        .b_rx_dq     (b_rx_dq),
        .a_rx_vld    (a_rx_vld),
        .a_rx_dq     (a_rx_dq),
        .dir         (dir),
        .collision   (collision)
`ifdef BIDIR_DLY_COLL_CNT_EN
        ,
        .coll_cnt    (coll_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: each delivered word is booked on a timeline keyed by edge number.
    function automatic int clampd(input int c);
        return (c < 1) ? 1 : ((c > MAX_DLY) ? MAX_DLY : c);
    endfunction

    int               edge_no  = 0;
    bit               model_ok = 1'b0;
    int               m_dir    = 0;
    bit               m_coll   = 1'b0;
    int               m_cnt    = 0;
    int               m_da     = 1;
    int               m_db     = 1;
    int               last_del = 0;
    bit               coll_now;
    logic [LANES-1:0] exp_b [int];
    logic [LANES-1:0] exp_a [int];

    always @(posedge clk) begin
        edge_no++;
        if (rst) begin
            model_ok = 1'b1;
            m_dir    = 0;
            m_coll   = 1'b0;
            m_cnt    = 0;
            m_da     = 1;
            m_db     = 1;
            last_del = 0;
            exp_a.delete();
            exp_b.delete();
        end else begin
            coll_now = 1'b0;
            case (m_dir)
                0: begin
                    m_da = clampd(int'(cfg_dly_a2b));
                    m_db = clampd(int'(cfg_dly_b2a));
                    if (a_oe && b_oe) coll_now = 1'b1;
                    else if (a_oe) begin
                        exp_b[edge_no + m_da] = a_dq;
                        last_del = edge_no + m_da;
                        m_dir = 1;
                    end else if (b_oe) begin
                        exp_a[edge_no + m_db] = b_dq;
                        last_del = edge_no + m_db;
                        m_dir = 2;
                    end
                end
                1: begin
                    if (b_oe) coll_now = 1'b1;
                    if (a_oe) begin
                        exp_b[edge_no + m_da] = a_dq;
                        last_del = edge_no + m_da;
                    end else m_dir = 3;
                end
                2: begin
                    if (a_oe) coll_now = 1'b1;
                    if (b_oe) begin
                        exp_a[edge_no + m_db] = b_dq;
                        last_del = edge_no + m_db;
                    end else m_dir = 3;
                end
                default: begin
                    if (a_oe || b_oe) coll_now = 1'b1;
                    if (last_del < edge_no) m_dir = 0;
                end
            endcase
            if (coll_now) begin
                m_coll = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            check("dir", 32'(dir), 32'(m_dir));
            check("collision", 32'(collision), 32'(m_coll));
            check("b_rx_vld", 32'(b_rx_vld), 32'(exp_b.exists(edge_no)));
            check("b_rx_dq", 32'(b_rx_dq), exp_b.exists(edge_no) ? 32'(exp_b[edge_no]) : 32'd0);
            check("a_rx_vld", 32'(a_rx_vld), 32'(exp_a.exists(edge_no)));
            check("a_rx_dq", 32'(a_rx_dq), exp_a.exists(edge_no) ? 32'(exp_a[edge_no]) : 32'd0);
`ifdef BIDIR_DLY_COLL_CNT_EN
            check("coll_cnt", 32'(coll_cnt), 32'(m_cnt));
`endif
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        a_oe = 1'b0;
        b_oe = 1'b0;
        a_dq = '0;
        b_dq = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    // One-word A2B transfer; optionally rewrites cfg right after the start edge.
    task automatic measure_a2b(input string nm, input int exp_lat, input int mid_cfg);
        int lat;
        lat  = -1;
        a_oe = 1'b1;
        a_dq = LANES'($urandom_range(1, 255));
        step();
        a_oe = 1'b0;
        if (mid_cfg >= 0) cfg_dly_a2b = DLYW'(mid_cfg);
        for (int k = 1; k <= 20; k++) begin
            step();
            if (b_rx_vld && lat < 0) lat = k;
        end
        check(nm, 32'(lat), 32'(exp_lat));
    endtask

    initial begin
        step();
        check("rst_dir", 32'(dir), 32'd0);
        check("rst_collision", 32'(collision), 32'd0);
        check("rst_rx_vld", 32'({a_rx_vld, b_rx_vld}), 32'd0);
        check("rst_rx_dq", 32'({a_rx_dq, b_rx_dq}), 32'd0);
        rst = 1'b0;

        // Single word A->B, delay 3.
        cfg_dly_a2b = DLYW'(3);
        step();
        a_oe = 1'b1;
        a_dq = 8'hFF;
        step();
        check("t1_dir_start", 32'(dir), 32'd1);
        idle_inputs();
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t1_b_vld", 32'(b_rx_vld), 32'(k == 3));
            check("t1_b_dq", 32'(b_rx_dq), (k == 3) ? 32'hFF : 32'h0);
            check("t1_dir", 32'(dir), (k == 4) ? 32'd0 : 32'd3);
        end

        // Four-word burst B->A, delay 5.
        cfg_dly_b2a = DLYW'(5);
        step();
        for (int k = 0; k <= 9; k++) begin
            b_oe = (k < 4);
            b_dq = (k < 4) ? LANES'(k + 1) : '0;
            step();
            check("t2_a_vld", 32'(a_rx_vld), 32'(k >= 5 && k <= 8));
            check("t2_a_dq", 32'(a_rx_dq), (k >= 5 && k <= 8) ? 32'(k - 4) : 32'd0);
            check("t2_dir", 32'(dir), (k <= 3) ? 32'd2 : ((k <= 8) ? 32'd3 : 32'd0));
        end
        idle_inputs();

        // Both sides drive in IDLE.
        do_reset();
        a_oe = 1'b1; b_oe = 1'b1; a_dq = 8'hAA; b_dq = 8'hA5;
        step();
        check("t3_collision", 32'(collision), 32'd1);
        check("t3_dir", 32'(dir), 32'd0);
`ifdef BIDIR_DLY_COLL_CNT_EN
        check("t3_coll_cnt", 32'(coll_cnt), 32'd1);
`endif
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            step();
            check("t3_no_rx", 32'({a_rx_vld, b_rx_vld}), 32'd0);
            check("t3_dir_idle", 32'(dir), 32'd0);
        end

        // Opposite side barges in during an A->B transfer.
        do_reset();
        cfg_dly_a2b = DLYW'(4);
        step();
        a_oe = 1'b1; a_dq = 8'h5A;
        step();
        a_oe = 1'b0; b_oe = 1'b1; b_dq = 8'hA5;
        step();
        check("t4_collision", 32'(collision), 32'd1);
        check("t4_dir_turn", 32'(dir), 32'd3);
        idle_inputs();
        for (int k = 2; k <= 6; k++) begin
            step();
            check("t4_b_vld", 32'(b_rx_vld), 32'(k == 4));
            check("t4_b_dq", 32'(b_rx_dq), (k == 4) ? 32'h5A : 32'h0);
            check("t4_a_vld", 32'(a_rx_vld), 32'd0);
        end

        // Delay clamping and mid-transfer cfg changes.
        do_reset();
        cfg_dly_a2b = DLYW'(0);
        step();
        measure_a2b("t5_lat_cfg0", 1, -1);
        cfg_dly_a2b = DLYW'(15);
        step();
        measure_a2b("t5_lat_cfg15", 15, -1);
        measure_a2b("t5_lat_mid_change", 15, 2);
        measure_a2b("t5_lat_after_change", 2, -1);

        // Reset with three words in flight.
        do_reset();
        cfg_dly_a2b = DLYW'(10);
        step();
        for (int k = 0; k < 3; k++) begin
            a_oe = 1'b1;
            a_dq = LANES'(8'h11 * (k + 1));
            step();
        end
        a_oe = 1'b0; b_oe = 1'b1; b_dq = 8'h77;
        step();
        idle_inputs();
        step();
        check("t6_coll_before_rst", 32'(collision), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t6_rx_vld", 32'({a_rx_vld, b_rx_vld}), 32'd0);
        check("t6_rx_dq", 32'({a_rx_dq, b_rx_dq}), 32'd0);
        check("t6_dir", 32'(dir), 32'd0);
        check("t6_collision", 32'(collision), 32'd0);
        for (int k = 0; k < 16; k++) begin
            step();
            check("t6_no_late", 32'(b_rx_vld), 32'd0);
        end

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            rst  = ($urandom_range(0, 299) == 0);
            a_oe = ($urandom_range(0, 2) == 0);
            b_oe = ($urandom_range(0, 3) == 0);
            a_dq = LANES'($urandom);
            b_dq = LANES'($urandom);
            if ($urandom_range(0, 19) == 0) cfg_dly_a2b = DLYW'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) cfg_dly_b2a = DLYW'($urandom_range(0, 15));
            step();
        end
        rst = 1'b0;
        idle_inputs();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/bidir_dly_line.md
BIDIR_DLY_LINE -- requirements
Module: bidir_dly_line

Interface
REQ-001 SHALL have parameter LANES, default 8: data lanes per direction.
REQ-002 SHALL have parameter MAX_DLY, default 15: maximum delay in clock cycles, at least 1.
REQ-003 SHALL have parameter DLYW, default 4: width of the delay configuration inputs; 2^DLYW SHALL exceed MAX_DLY.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port a_oe, input, 1 bit: side A (PHY) drives the line.
REQ-007 SHALL have port a_dq, input, LANES bits: side A drive data.
REQ-008 SHALL have port b_oe, input, 1 bit: side B (MEM) drives the line.
REQ-009 SHALL have port b_dq, input, LANES bits: side B drive data.
REQ-010 SHALL have ports cfg_dly_a2b and cfg_dly_b2a, input, DLYW bits each: requested delay per direction.
REQ-011 SHALL have ports b_rx_vld (1 bit) and b_rx_dq (LANES bits), outputs: A-to-B data arriving at side B.
REQ-012 SHALL have ports a_rx_vld (1 bit) and a_rx_dq (LANES bits), outputs: B-to-A data arriving at side A.
REQ-013 SHALL have port dir, output, 2 bits: FSM state, encoded IDLE=0, A2B=1, B2A=2, TURN=3.
REQ-014 SHALL have port collision, output, 1 bit: sticky flag, set when both sides drive.

Function
REQ-015 SHALL hold one shift pipeline per direction, MAX_DLY stages deep; each stage carries {vld, LANES data}.
REQ-016 SHALL use effective delay D = clamp(latched cfg, 1, MAX_DLY): 0 maps to 1, values above MAX_DLY map to MAX_DLY.
REQ-017 SHALL latch cfg_dly_a2b and cfg_dly_b2a only while dir is IDLE; changes during A2B, B2A or TURN SHALL have no effect until the FSM returns to IDLE.
REQ-018 SHALL present data injected at rising edge N on the far-side rx outputs after edge N+D; rx_vld SHALL equal the injected valid bit.
REQ-019 SHALL output rx_dq = 0 whenever the matching rx_vld = 0.
REQ-020 SHALL leave IDLE as follows: a_oe=1 and b_oe=0 goes to A2B and injects a_dq that cycle; b_oe=1 and a_oe=0 goes to B2A and injects b_dq that cycle.
REQ-021 SHALL, in IDLE with a_oe=1 and b_oe=1, set collision, inject nothing and stay in IDLE.
REQ-022 SHALL, in A2B, inject a_dq every cycle a_oe=1; when a_oe=0 it SHALL go to TURN.
REQ-023 SHALL apply REQ-022 to B2A with b_oe and b_dq.
REQ-024 SHALL stay in TURN until the active pipeline holds no valid stage, then go to IDLE; a new drive can start only from IDLE.
REQ-025 SHALL, when the opposite side drives during A2B, B2A or TURN, set collision and drop that side's data; the active transfer SHALL continue unaffected.
REQ-026 SHALL, when the active side re-asserts oe during TURN, count it as a collision and drop its data.
REQ-027 SHALL keep collision set until rst.

Reset
REQ-028 SHALL, while rst=1 at a rising edge, clear every pipeline stage, set dir to IDLE, clear collision, and load 1 into both latched delays.
REQ-029 SHALL drive a_rx_vld, b_rx_vld, a_rx_dq and b_rx_dq to 0 in the cycle after a reset edge.
REQ-030 SHALL discard in-flight data when reset is asserted mid-transfer, with no late delivery after reset.

Configuration
REQ-031 SHALL, with BIDIR_DLY_COLL_CNT_EN defined, add output coll_cnt (8 bits, reset 0) that increments once per cycle in which a collision condition is detected and saturates at 255.
REQ-032 SHALL, without BIDIR_DLY_COLL_CNT_EN, have no coll_cnt port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-033 SHALL cover: cfg_dly_a2b=3, a_oe=1 for one cycle with a_dq=0xFF -> b_rx_vld=1 with b_rx_dq=0xFF exactly 3 cycles later; dir goes 1,3,0.
REQ-034 SHALL cover: cfg_dly_b2a=5, b_oe=1 for 4 cycles with data 0x01..0x04 -> a_rx shows 0x01..0x04 on consecutive cycles starting 5 cycles later; then IDLE.
REQ-035 SHALL cover: a_oe and b_oe both asserted in IDLE with 0xAA/0xA5 -> collision=1, no rx_vld on either side, dir stays 0; with macro, coll_cnt=1.
REQ-036 SHALL cover: A2B 0x5A started, b_oe asserted one cycle later with 0xA5 -> 0x5A still delivered to B, a_rx_vld stays 0, collision=1.
REQ-037 SHALL cover: cfg_dly_a2b=0, then 15 (MAX_DLY=15) -> effective latency 1, then 15; cfg changed mid-transfer leaves the latency of that transfer unchanged.
REQ-038 SHALL cover: rst pulsed while 3 words are in flight -> all rx outputs 0, dir=0, collision=0, and none of the 3 words delivered afterwards.
